// File: rtl/la_parity_pkg.sv
// rtl/la_parity_pkg.sv - shared types and tree-sizing helpers for the streaming parity block
package la_parity_pkg;

  localparam int MAXLV = 5;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic check;
  } side_t;

  // Width of the vector entering a given tree level (level 0 is the raw beat).
  function automatic int grp(input int n, input int level);
    int w;
    w = n;
    for (int i = 0; i < level; i++) begin
      w = (w + 3) / 4;
    end
    return w;
  endfunction

  function automatic int lv(input int n);
    int l;
    l = 0;
    for (int i = 0; i <= MAXLV; i++) begin
      if (grp(n, i) > 1) begin
        l = i + 1;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/la_xor4_level.sv
// rtl/la_xor4_level.sv - one 4:1 XOR reduction level with optional retiming of data and sideband
module la_xor4_level
  import la_parity_pkg::*;
#(
  parameter int W   = 4,
  parameter bit REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [W-1:0]         data,
  input  side_t                side,
  output logic [(W+3)/4-1:0]   red,
  output side_t                red_side
);

  localparam int OW = (W + 3) / 4;

  logic [OW*4-1:0] pad;
  logic [OW-1:0]   red_c;

  // A short final group is zero-padded so it reduces like a full nibble.
  always_comb begin
    pad        = '0;
    pad[W-1:0] = data;
    red_c      = '0;
    for (int g = 0; g < OW; g++) begin
      red_c[g] = ^pad[g*4 +: 4];
    end
  end

  generate
    if (REG) begin : g_reg
      always_ff @(posedge clk) begin
        if (!nreset) begin
          red_side <= '0;
        end else begin
          red_side <= side;
        end
      end

      always_ff @(posedge clk) begin
        red <= red_c;
      end
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = ^{clk, nreset};
      assign red        = red_c;
      assign red_side   = side;
    end
  endgenerate

endmodule

// File: rtl/la_parity_stream.sv
// rtl/la_parity_stream.sv - pipelined word parity generator with framed accumulate-and-compare
module la_parity_stream
  import la_parity_pkg::*;
#(
  parameter int    N    = 32,
  parameter int    PIPE = 1,
  parameter bit    ODD  = 1'b0,
  parameter string PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_check,
  output logic         out_valid,
  output logic         out_parity,
  output logic         frame_valid,
  output logic         frame_parity,
  output logic         frame_error,
  output logic         frame_abort
);

  localparam int    LV          = lv(N);
  localparam bit    OUT_REG     = (PIPE == 0) || (LV == 0);
  localparam string prop_unused = PROP;

  side_t in_side;
  logic  tree_bit;
  side_t tree_side;
  logic  p_raw;
  side_t st;

  assign in_side = {in_valid, in_first, in_last, in_check};

  genvar i;
  generate
    for (i = 0; i < LV; i++) begin : g_lvl
      localparam int WI = grp(N, i);
      localparam int WO = grp(N, i + 1);

      logic [WI-1:0] din;
      side_t         sin;
      logic [WO-1:0] q;
      side_t         qs;

      if (i == 0) begin : g_src
        assign din = in_data;
        assign sin = in_side;
      end else begin : g_src
        assign din = g_lvl[i-1].q;
        assign sin = g_lvl[i-1].qs;
      end

      la_xor4_level #(
        .W   (WI),
        .REG (PIPE != 0)
      ) u_level (
        .clk      (clk),
        .nreset   (nreset),
        .data     (din),
        .side     (sin),
        .red      (q),
        .red_side (qs)
      );
    end

    if (LV == 0) begin : g_tail
      assign tree_bit  = in_data[0];
      assign tree_side = in_side;
    end else begin : g_tail
      assign tree_bit  = g_lvl[LV-1].q[0];
      assign tree_side = g_lvl[LV-1].qs;
    end

    // Combinational trees and the degenerate 1-bit case still get one output register.
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (!nreset) begin
          st <= '0;
        end else begin
          st <= tree_side;
        end
      end

      always_ff @(posedge clk) begin
        p_raw <= tree_bit;
      end
    end else begin : g_out_wire
      assign st    = tree_side;
      assign p_raw = tree_bit;
    end
  endgenerate

  assign out_valid  = st.valid;
  assign out_parity = st.valid & (p_raw ^ ODD);

  frame_state_t state, state_d;
  logic         acc, acc_d;
  logic         fv_d, fp_d, fe_d, fa_d;
  logic         r;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state        <= IDLE;
      acc          <= 1'b0;
      frame_valid  <= 1'b0;
      frame_parity <= 1'b0;
      frame_error  <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      state        <= state_d;
      acc          <= acc_d;
      frame_valid  <= fv_d;
      frame_parity <= fp_d;
      frame_error  <= fe_d;
      frame_abort  <= fa_d;
    end
  end

  // acc is zero whenever no frame is open, so a stray last behaves as an implicit first.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    fv_d    = 1'b0;
    fp_d    = 1'b0;
    fe_d    = 1'b0;
    fa_d    = 1'b0;
    r       = 1'b0;
    if (st.valid) begin
      if (st.last) begin
        r       = (st.first ? 1'b0 : acc) ^ p_raw;
        fv_d    = 1'b1;
        fp_d    = r ^ ODD;
        fe_d    = (r ^ ODD) != st.check;
        fa_d    = st.first && (state == OPEN);
        acc_d   = 1'b0;
        state_d = IDLE;
      end else if (st.first) begin
        fa_d    = (state == OPEN);
        acc_d   = p_raw;
        state_d = OPEN;
      end else begin
        acc_d   = acc ^ p_raw;
        state_d = OPEN;
      end
    end
  end

endmodule
